// File: rtl/fp_significand_align_if.sv
// Handshake bundle for the significand alignment stage: an input beat
// (sign, magnitude, shift) and an aligned two's-complement result beat.
interface fp_significand_align_if #(
  parameter int MANT_W  = 24,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 32
);
  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic [MANT_W-1:0]  in_sig;
  logic [SHIFT_W-1:0] in_shift;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_zero;
  logic               out_sticky;

  // Producer of input beats and consumer of results
  modport master (
    output in_valid, in_sign, in_sig, in_shift, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_sticky
  );

  // The alignment stage itself
  modport slave (
    input  in_valid, in_sign, in_sig, in_shift, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_sticky
  );
endinterface

// File: rtl/fp_significand_align.sv
// FPU front-end: right-aligns a sign-magnitude significand with guard/round/
// sticky bits, then converts it to a sign-extended two's-complement operand.
// Two register stages, one result per cycle, full valid/ready backpressure.
module fp_significand_align #(
  parameter int MANT_W  = 24,
  parameter int GUARD_W = 3,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  fp_significand_align_if.slave bus
);
  localparam int EXT_W = MANT_W + GUARD_W;

  generate
    if (OUT_W < EXT_W + 1) begin : g_bad_width
      $error("fp_significand_align: OUT_W must be at least MANT_W+GUARD_W+1");
    end
  endgenerate

  // Returns {sticky, magnitude}; shifted-out bits are ORed into the LSB.
  function automatic logic [EXT_W:0] align(input logic [MANT_W-1:0] sig,
                                           input logic [SHIFT_W-1:0] sh);
    logic [EXT_W-1:0] ext;
    logic [EXT_W-1:0] mask;
    logic [EXT_W-1:0] mag;
    logic             lost;
    ext = {sig, {GUARD_W{1'b0}}};
    if (int'(sh) >= EXT_W) begin
      lost = |sig;
      mag  = EXT_W'(lost);
    end else begin
      mask   = ~({EXT_W{1'b1}} << sh);
      lost   = |(ext & mask);
      mag    = ext >> sh;
      mag[0] = mag[0] | lost;
    end
    return {lost, mag};
  endfunction

  // Negation wraps at OUT_W bits; the magnitude never reaches the sign bit.
  function automatic logic signed [OUT_W-1:0] to_twos(input logic sign,
                                                      input logic [EXT_W-1:0] mag);
    logic signed [OUT_W-1:0] zext;
    zext = OUT_W'(mag);
    return sign ? (~zext + OUT_W'(1)) : zext;
  endfunction

  logic                    vld_p1;
  logic                    vld_p2;
  logic                    adv2;
  logic [EXT_W:0]          align_res;
  logic                    sign_p1;
  logic                    sticky_p1;
  logic [EXT_W-1:0]        mag_p1;
  logic signed [OUT_W-1:0] data_p2;
  logic                    zero_p2;
  logic                    sticky_p2;

  // Stage 2 frees up when empty or drained; stage 1 accepts when it can move on.
  assign adv2         = !vld_p2 || bus.out_ready;
  assign bus.in_ready = !vld_p1 || adv2;
  assign align_res    = align(bus.in_sig, bus.in_shift);

  // Per-stage valid bits; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (bus.in_ready) vld_p1 <= bus.in_valid;
      if (adv2)         vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: align magnitude, capture sign and sticky ----
  always_ff @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) begin
      mag_p1    <= align_res[EXT_W-1:0];
      sticky_p1 <= align_res[EXT_W];
      sign_p1   <= bus.in_sign;
    end
  end

  // ---- stage 2: convert to two's complement, held while stalled ----
  always_ff @(posedge clk) begin
    if (vld_p1 && adv2) begin
      data_p2   <= to_twos(sign_p1, mag_p1);
      zero_p2   <= (mag_p1 == '0);
      sticky_p2 <= sticky_p1;
    end
  end

  // Outputs read as zero whenever no result is present (including after reset).
  assign bus.out_valid  = vld_p2;
  assign bus.out_data   = vld_p2 ? data_p2 : '0;
  assign bus.out_zero   = vld_p2 && zero_p2;
  assign bus.out_sticky = vld_p2 && sticky_p2;
endmodule

// File: tb/tb_fp_significand_align.sv
// Bench for fp_significand_align: directed vectors, latency, stall/ordering
// under random backpressure, and reset with both stages occupied.
module tb_fp_significand_align;
  localparam int MANT_W  = 24;
  localparam int GUARD_W = 3;
  localparam int SHIFT_W = 5;
  localparam int OUT_W   = 32;

  typedef struct {
    logic [OUT_W-1:0] data;
    bit               zero;
    bit               sticky;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fp_significand_align_if #(.MANT_W(MANT_W), .SHIFT_W(SHIFT_W), .OUT_W(OUT_W)) bus();

  fp_significand_align #(
    .MANT_W(MANT_W), .GUARD_W(GUARD_W), .SHIFT_W(SHIFT_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact division/remainder view of the right shift.
  function automatic exp_t model(input bit s, input longint unsigned sig, input int sh);
    longint unsigned ext, div, q, rem, mag, val, modv;
    exp_t e;
    ext  = sig * (64'd1 << GUARD_W);
    modv = 64'd1 << OUT_W;
    if (sh >= MANT_W + GUARD_W) begin
      e.sticky = (sig != 0);
      mag      = e.sticky ? 64'd1 : 64'd0;
    end else begin
      div      = 64'd1 << sh;
      q        = ext / div;
      rem      = ext % div;
      e.sticky = (rem != 0);
      mag      = e.sticky ? (q | 64'd1) : q;
    end
    val    = s ? ((modv - mag) % modv) : mag;
    e.data = val[OUT_W-1:0];
    e.zero = (mag == 0);
    return e;
  endfunction

  task automatic directed(input string tag, input bit s, input logic [MANT_W-1:0] sig,
                          input logic [SHIFT_W-1:0] sh, input logic [OUT_W-1:0] exp_data,
                          input bit exp_sticky);
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_sign   = s;
    bus.in_sig    = sig;
    bus.in_shift  = sh;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, bus.in_ready, 1);
    lat = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_data"}, bus.out_data, exp_data);
    check({tag, "_zero"}, bus.out_zero, (exp_data == 0));
    check({tag, "_sticky"}, bus.out_sticky, exp_sticky);
  endtask

  // Random traffic; every cycle with out_valid the output must match the
  // oldest outstanding expected result (so held values are checked too).
  task automatic run(input int nbeats, input bit always_valid);
    int   sent, received, cyc;
    bit   pend;
    exp_t e;
    sent = 0; received = 0; cyc = 0; pend = 0;
    while (received < nbeats && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (!pend) begin
        if (sent < nbeats && (always_valid || $urandom_range(0, 3) != 0)) begin
          bus.in_valid = 1'b1;
          bus.in_sign  = 1'($urandom_range(0, 1));
          bus.in_sig   = ($urandom_range(0, 7) == 0) ? '0 : MANT_W'($urandom());
          bus.in_shift = SHIFT_W'($urandom_range(0, 31));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          check("rand_data", bus.out_data, exp_q[0].data);
          check("rand_zero", bus.out_zero, exp_q[0].zero);
          check("rand_sticky", bus.out_sticky, exp_q[0].sticky);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            received++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_sign, longint'(bus.in_sig), int'(bus.in_shift)));
        sent++;
        pend = 0;
      end else begin
        pend = bus.in_valid;
      end
    end
    check("drain_count", received, nbeats);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_sig    = '0;
    bus.in_shift  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_zero", bus.out_zero, 0);
    check("rst_out_sticky", bus.out_sticky, 0);
    check("rst_in_ready", bus.in_ready, 1);
    reset = 1'b0;

    directed("pos_hidden",  1'b0, 24'h800000, 5'd0,  32'h04000000, 1'b0);
    directed("neg_hidden",  1'b1, 24'h800000, 5'd0,  32'hFC000000, 1'b0);
    directed("neg_zero",    1'b1, 24'h000000, 5'd0,  32'h00000000, 1'b0);
    directed("shift1",      1'b0, 24'h800001, 5'd1,  32'h02000004, 1'b0);
    directed("shift4_lost", 1'b0, 24'h000001, 5'd4,  32'h00000001, 1'b1);
    directed("shift31_neg", 1'b1, 24'h800000, 5'd31, 32'hFFFFFFFF, 1'b1);
    directed("shift27_zero",1'b0, 24'h000000, 5'd27, 32'h00000000, 1'b0);

    // Back-to-back input with random backpressure, then bursty traffic
    run(10, 1'b1);
    run(300, 1'b0);

    // Fill both stages under backpressure, then reset
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sign   = 1'b0;
    bus.in_sig    = 24'h123456;
    bus.in_shift  = 5'd2;
    @(negedge clk);
    bus.in_sig    = 24'h654321;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    #1;
    check("full_in_ready", bus.in_ready, 0);
    check("full_out_valid", bus.out_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_data", bus.out_data, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_stale", bus.out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
